// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: legal oversample ratios, vote helper and prescale sanitiser.
package uart_rx_pkg;

  localparam int unsigned PS_W       = 6;
  localparam int unsigned BIT_CNT_DW = 4;

  localparam logic [PS_W-1:0] PS_8  = PS_W'(8);
  localparam logic [PS_W-1:0] PS_16 = PS_W'(16);
  localparam logic [PS_W-1:0] PS_32 = PS_W'(32);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Anything outside the legal ratio set falls back to 8x oversampling.
  function automatic logic [PS_W-1:0] eff_prescale(input logic [PS_W-1:0] ps);
    logic [PS_W-1:0] r;
    case (ps)
      PS_8, PS_16, PS_32: r = ps;
      default:            r = PS_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (1) level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bit_sampler.sv
// UART RX oversampling front end: edge/bit counting and 3-sample mid-bit majority vote.
module bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  bit_end,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic s_rx;

  logic [PRESCALE_W-1:0] eff_ps;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last_edge;

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  smp0_q, smp0_d;
  logic                  smp1_q, smp1_d;
  logic                  sbit_q, sbit_d;
  logic                  valid_q, valid_d;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (s_rx)
  );

  assign eff_ps    = PRESCALE_W'(eff_prescale(PS_W'(prescale)));
  assign mid       = eff_ps >> 1;
  assign last_edge = eff_ps - PRESCALE_W'(1);

  // Counter wrap uses >= so an illegal mid-frame prescale change cannot run away.
  always_comb begin
    edge_d  = edge_q;
    bit_d   = bit_q;
    smp0_d  = smp0_q;
    smp1_d  = smp1_q;
    sbit_d  = sbit_q;
    valid_d = 1'b0;
    if (samp_en) begin
      if (edge_q >= last_edge) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_CNT_W'(1);
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
      end
      if (edge_q == mid - PRESCALE_W'(1)) smp0_d = s_rx;
      if (edge_q == mid)                  smp1_d = s_rx;
      if (edge_q == mid + PRESCALE_W'(1)) begin
        sbit_d  = maj3(smp0_q, smp1_q, s_rx);
        valid_d = 1'b1;
      end
    end else begin
      edge_d = '0;
      bit_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q  <= '0;
      bit_q   <= '0;
      smp0_q  <= 1'b1;
      smp1_q  <= 1'b1;
      sbit_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      smp0_q  <= smp0_d;
      smp1_q  <= smp1_d;
      sbit_q  <= sbit_d;
      valid_q <= valid_d;
    end
  end

  assign sampled_bit  = sbit_q;
  assign sample_valid = valid_q;
  assign bit_end      = samp_en && (edge_q == last_edge);
  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;

endmodule

// File: tb/tb_bit_sampler.sv
// Scoreboard bench for bit_sampler: per-cycle s_rx patterns, expected votes queued at drive time.
module tb_bit_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       samp_en;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       sample_valid;
  logic       bit_end;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int mon_eff = 8;
  int mon_mid = 4;
  int strobes = 0;
  int bends = 0;
  bit want[$];
  bit exp_q[$];

  bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .samp_en      (samp_en),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .bit_end      (bit_end),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (rst) samp_en |-> $stable(prescale))
    else $error("prescale changed while samp_en=1");

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit bmaj(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // want[c] is the synchronised line value seen at enabled cycle c; rx_in leads it by 2 clocks.
  task automatic run(input int ps, input int eff, input int n_en);
    int m;
    m = eff / 2;
    strobes = 0;
    bends   = 0;
    for (int b = 0; b * eff + m + 1 < n_en; b++)
      exp_q.push_back(bmaj(want[b*eff+m-1], want[b*eff+m], want[b*eff+m+1]));
    for (int j = -2; j < n_en; j++) begin
      @(negedge clk);
      if (j == -2) begin
        prescale = 6'(ps);
        mon_eff  = eff;
        mon_mid  = m;
      end
      rx_in   = (j + 2 < want.size()) ? want[j+2] : 1'b1;
      samp_en = (j >= 0);
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        strobes++;
        chk("strobe_edge", 32'(edge_cnt), 32'(mon_mid + 2));
        if (exp_q.size() == 0) chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        else                   chk("sampled_bit", 32'(sampled_bit), 32'(exp_q.pop_front()));
      end
      if (bit_end) begin
        bends++;
        chk("bit_end_edge", 32'(edge_cnt), 32'(mon_eff - 1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit frame[10];
    logic [7:0] data;
    rst = 1'b1; rx_in = 1'b1; samp_en = 1'b0; prescale = 6'd8;
    repeat (3) @(negedge clk);
    chk("rst_sbit", 32'(sampled_bit), 32'd1);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_bend", 32'(bit_end), 32'd0);
    chk("rst_edge", 32'(edge_cnt), 32'd0);
    chk("rst_bcnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset mid-frame at edge_cnt=5, bit_cnt=3
    want.delete();
    for (int i = 0; i < 31; i++) want.push_back(1'b0);
    run(8, 8, 29);
    chk("s1_edge", 32'(edge_cnt), 32'd5);
    chk("s1_bcnt", 32'(bit_cnt), 32'd3);
    chk("s1_sbit_pre", 32'(sampled_bit), 32'd0);
    chk("s1_strobes", 32'(strobes), 32'd3);
    rst = 1'b1;
    #1;
    chk("s1_rst_sbit", 32'(sampled_bit), 32'd1);
    chk("s1_rst_edge", 32'(edge_cnt), 32'd0);
    chk("s1_rst_bcnt", 32'(bit_cnt), 32'd0);
    chk("s1_rst_valid", 32'(sample_valid), 32'd0);
    chk("s1_rst_bend", 32'(bit_end), 32'd0);
    @(negedge clk);
    rst = 1'b0; samp_en = 1'b0; rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("s1_idle_edge", 32'(edge_cnt), 32'd0);

    // 2: prescale 8, line low for one bit
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(1'b0);
    run(8, 8, 8);
    chk("s2_strobes", 32'(strobes), 32'd1);
    chk("s2_bends", 32'(bends), 32'd1);
    chk("s2_bcnt", 32'(bit_cnt), 32'd1);
    chk("s2_edge", 32'(edge_cnt), 32'd0);

    // 3: prescale 16, single-sample glitches around mid-bit
    want.delete();
    for (int i = 0; i < 16; i++) want.push_back(i == 7 || i == 9);
    for (int i = 0; i < 16; i++) want.push_back(!(i == 7 || i == 8));
    run(16, 16, 32);
    chk("s3_strobes", 32'(strobes), 32'd2);
    chk("s3_bcnt", 32'(bit_cnt), 32'd2);

    // 4: prescale 32, 10-bit frame carrying 0x35
    data = 8'h35;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = data[i];
    frame[9] = 1'b1;
    want.delete();
    for (int b = 0; b < 10; b++)
      for (int i = 0; i < 32; i++) want.push_back(frame[b]);
    run(32, 32, 320);
    chk("s4_strobes", 32'(strobes), 32'd10);
    chk("s4_bends", 32'(bends), 32'd10);
    chk("s4_bcnt", 32'(bit_cnt), 32'd10);
    chk("s4_sbit", 32'(sampled_bit), 32'd1);

    // 5: prescale 16, enable dropped at edge_cnt=5
    want.delete();
    for (int i = 0; i < 16; i++) want.push_back(1'b0);
    run(16, 16, 5);
    chk("s5_edge_pre", 32'(edge_cnt), 32'd5);
    samp_en = 1'b0;
    @(negedge clk);
    #1;
    chk("s5_edge", 32'(edge_cnt), 32'd0);
    chk("s5_bcnt", 32'(bit_cnt), 32'd0);
    chk("s5_sbit", 32'(sampled_bit), 32'd1);
    repeat (12) @(negedge clk);
    chk("s5_strobes", 32'(strobes), 32'd0);

    // 6: illegal prescale 12 behaves as 8
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(1'b0);
    for (int i = 0; i < 8; i++) want.push_back(1'b1);
    run(12, 8, 16);
    chk("s6_strobes", 32'(strobes), 32'd2);
    chk("s6_bends", 32'(bends), 32'd2);
    chk("s6_bcnt", 32'(bit_cnt), 32'd2);
    chk("s6_sbit", 32'(sampled_bit), 32'd1);

    @(negedge clk);
    samp_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
